// File: rtl/ps2_pkg.sv
// Shared constants, decoder state encoding and event layout for the PS/2 key-event path.
package ps2_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned KEY_W  = CODE_W + 1;
    localparam int unsigned EV_W   = CODE_W + 2;

    localparam logic [CODE_W-1:0] E0      = 8'hE0;
    localparam logic [CODE_W-1:0] E1      = 8'hE1;
    localparam logic [CODE_W-1:0] F0      = 8'hF0;
    localparam logic [CODE_W-1:0] SHIFT_L = 8'h12;
    localparam logic [CODE_W-1:0] SHIFT_R = 8'h59;
    localparam logic [CODE_W-1:0] CAPS    = 8'h58;

    // Bytes following E1 that belong to the Pause sequence
    localparam logic [2:0] SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } dec_state_t;

    typedef struct packed {
        logic              brk;
        logic              ext;
        logic [CODE_W-1:0] code;
    } key_event_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises both lines, debounces ps2c and shifts in
// 11-bit frames on filtered falling edges, flagging bad start/stop/parity.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2c,
    input  logic              ps2d,
    output logic              byte_valid,
    output logic [CODE_W-1:0] rx_data,
    output logic              frame_err
);

    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] filt;
    logic                  level;
    logic [9:0]            shreg;
    logic [3:0]            bit_cnt;
    logic                  fall_c;
    logic                  frame_ok_c;

    assign fall_c     = level && (filt == '0);
    // shreg holds start..parity; the stop bit is taken straight from the line
    assign frame_ok_c = !shreg[0] && d_sync[1] && (^shreg[9:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync     <= 2'b11;
            d_sync     <= 2'b11;
            filt       <= '1;
            level      <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            rx_data    <= '0;
            frame_err  <= 1'b0;
        end else begin
            c_sync     <= {c_sync[0], ps2c};
            d_sync     <= {d_sync[0], ps2d};
            filt       <= {filt[FILTER_LEN-2:0], c_sync[1]};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (&filt) begin
                level <= 1'b1;
            end else if (filt == '0) begin
                level <= 1'b0;
            end
            if (fall_c) begin
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok_c) begin
                        byte_valid <= 1'b1;
                        rx_data    <= shreg[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {d_sync[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_events.sv
// PS/2 scan-code set 2 decoder: turns received bytes into make/break events,
// tracks modifier and selected key state, and queues events in a FWFT FIFO.
module ps2_key_events
    import ps2_pkg::*;
#(
    parameter int unsigned               FIFO_DEPTH  = 8,
    parameter int unsigned               FILTER_LEN  = 8,
    parameter int unsigned               NUM_TRACK   = 4,
    parameter logic [NUM_TRACK*KEY_W-1:0] TRACK_CODES = {9'h075, 9'h072, 9'h06B, 9'h074},
    parameter bit                        REPEAT_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2d,
    input  logic                 ps2c,
    input  logic                 rd_en,
    output logic [EV_W-1:0]      ev_data,
    output logic                 empty,
    output logic                 full,
    output logic                 shift_held,
    output logic                 caps_on,
    output logic [NUM_TRACK-1:0] held,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic              rx_valid;
    logic [CODE_W-1:0] rx_data;
    logic              rx_err;

    ps2_frame_rx #(
        .FILTER_LEN(FILTER_LEN)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .byte_valid(rx_valid),
        .rx_data   (rx_data),
        .frame_err (rx_err)
    );

    dec_state_t           state;
    logic [2:0]           skip_cnt;
    logic                 shift_l;
    logic                 shift_r;
    logic                 caps_held;
    key_event_t           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    logic                 emit_c;
    key_event_t           ev_c;
    logic [NUM_TRACK-1:0] hit_c;
    logic                 suppress_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 wr_c;

    // Event produced by the byte arriving this cycle, given the prefix state
    always_comb begin
        emit_c   = 1'b0;
        ev_c     = '0;
        ev_c.code = rx_data;
        if (rx_valid) begin
            case (state)
                ST_IDLE:    emit_c = !(rx_data inside {E0, F0, E1});
                ST_EXT: begin
                    emit_c   = (rx_data != F0);
                    ev_c.ext = 1'b1;
                end
                ST_BRK: begin
                    emit_c   = 1'b1;
                    ev_c.brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    emit_c   = 1'b1;
                    ev_c.brk = 1'b1;
                    ev_c.ext = 1'b1;
                end
                default:    emit_c = 1'b0;
            endcase
        end
    end

    // Entry 0 is the most significant field of TRACK_CODES
    always_comb begin
        hit_c = '0;
        for (int unsigned i = 0; i < NUM_TRACK; i++) begin
            hit_c[i] = (TRACK_CODES[(NUM_TRACK-1-i)*KEY_W +: KEY_W] == {ev_c.ext, ev_c.code});
        end
    end

    assign suppress_c = !REPEAT_EN && !ev_c.brk && (|(hit_c & held));
    assign push_c     = emit_c && !suppress_c;
    assign pop_c      = rd_en && !empty;
    assign wr_c       = push_c && (!full || pop_c);

    assign empty      = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign shift_held = shift_l | shift_r;
    assign ev_data    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            held      <= '0;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_held <= 1'b0;
            caps_on   <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (rx_err) begin
                frame_err <= 1'b1;
            end

            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == E0) begin
                            state <= ST_EXT;
                        end else if (rx_data == F0) begin
                            state <= ST_BRK;
                        end else if (rx_data == E1) begin
                            state    <= ST_SKIP;
                            skip_cnt <= SKIP_LEN;
                        end
                    end
                    ST_EXT:     state <= (rx_data == F0) ? ST_EXT_BRK : ST_IDLE;
                    ST_BRK,
                    ST_EXT_BRK: state <= ST_IDLE;
                    ST_SKIP: begin
                        skip_cnt <= skip_cnt - 3'd1;
                        if (skip_cnt <= 3'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                    default:    state <= ST_IDLE;
                endcase
            end

            // Key state follows the keyboard even when the queue drops the event
            if (push_c) begin
                for (int unsigned i = 0; i < NUM_TRACK; i++) begin
                    if (hit_c[i]) begin
                        held[i] <= !ev_c.brk;
                    end
                end
                if (!ev_c.ext && ev_c.code == SHIFT_L) begin
                    shift_l <= !ev_c.brk;
                end
                if (!ev_c.ext && ev_c.code == SHIFT_R) begin
                    shift_r <= !ev_c.brk;
                end
                if (!ev_c.ext && ev_c.code == CAPS) begin
                    if (!ev_c.brk && !caps_held) begin
                        caps_on <= !caps_on;
                    end
                    caps_held <= !ev_c.brk;
                end
            end

            if (push_c && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (wr_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_c && !pop_c) begin
                count <= count + CW'(1);
            end else if (!wr_c && pop_c) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= ev_c;
        end
    end

endmodule

// File: tb/tb_ps2_key_events.sv
// Bench for ps2_key_events: drives PS/2 frames into two instances (repeat on/off)
// and compares against a byte-level behavioural model of keyboard semantics.
module tb_ps2_key_events;

    localparam int unsigned DEPTH = 8;
    // Arrow keys are extended codes, so the tracked entries carry ext=1
    localparam logic [35:0] TRACK = {9'h175, 9'h172, 9'h16B, 9'h174};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;
    logic rd_en = 1'b0;

    logic [9:0] ev_data [2];
    logic [3:0] held [2];
    logic [1:0] empty, full, shift_held, caps_on, overflow, frame_err;

    logic [8:0] track_list [4] = '{9'h175, 9'h172, 9'h16B, 9'h174};
    logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

    logic [9:0] m_q [2][$];
    logic [3:0] m_held [2];
    bit         m_caps [2];
    bit         m_caps_held [2];
    bit         m_sl [2];
    bit         m_sr [2];
    bit         m_ovf [2];
    bit         m_ferr;
    bit         pfx_ext;
    bit         pfx_brk;
    int         skip_left;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ps2_key_events #(
        .FIFO_DEPTH(DEPTH), .FILTER_LEN(8), .NUM_TRACK(4), .TRACK_CODES(TRACK), .REPEAT_EN(1'b1)
    ) dut_rep (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rd_en(rd_en),
        .ev_data(ev_data[0]), .empty(empty[0]), .full(full[0]), .shift_held(shift_held[0]),
        .caps_on(caps_on[0]), .held(held[0]), .overflow(overflow[0]), .frame_err(frame_err[0])
    );

    ps2_key_events #(
        .FIFO_DEPTH(DEPTH), .FILTER_LEN(8), .NUM_TRACK(4), .TRACK_CODES(TRACK), .REPEAT_EN(1'b0)
    ) dut_norep (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rd_en(rd_en),
        .ev_data(ev_data[1]), .empty(empty[1]), .full(full[1]), .shift_held(shift_held[1]),
        .caps_on(caps_on[1]), .held(held[1]), .overflow(overflow[1]), .frame_err(frame_err[1])
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic model_clear;
        for (int k = 0; k < 2; k++) begin
            m_q[k].delete();
            m_held[k] = '0;
            m_caps[k] = 0; m_caps_held[k] = 0;
            m_sl[k] = 0; m_sr[k] = 0; m_ovf[k] = 0;
        end
        m_ferr = 0; pfx_ext = 0; pfx_brk = 0; skip_left = 0;
    endtask

    task automatic model_emit(input logic [9:0] ev);
        int idx;
        bit brk, ext;
        brk = ev[9];
        ext = ev[8];
        idx = -1;
        for (int t = 0; t < 4; t++) if (track_list[t] == ev[8:0]) idx = t;
        for (int k = 0; k < 2; k++) begin
            if (k == 1 && !brk && idx >= 0 && m_held[k][idx]) continue;
            if (idx >= 0) m_held[k][idx] = !brk;
            if (!ext && ev[7:0] == 8'h12) m_sl[k] = !brk;
            if (!ext && ev[7:0] == 8'h59) m_sr[k] = !brk;
            if (!ext && ev[7:0] == 8'h58) begin
                if (!brk && !m_caps_held[k]) m_caps[k] = !m_caps[k];
                m_caps_held[k] = !brk;
            end
            if (m_q[k].size() < DEPTH) m_q[k].push_back(ev);
            else m_ovf[k] = 1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (skip_left > 0) begin
            skip_left--;
        end else if (b == 8'hE1 && !pfx_ext && !pfx_brk) begin
            skip_left = 7;
        end else if (b == 8'hE0 && !pfx_ext && !pfx_brk) begin
            pfx_ext = 1;
        end else if (b == 8'hF0 && !pfx_brk) begin
            pfx_brk = 1;
        end else begin
            model_emit({pfx_brk, pfx_ext, b});
            pfx_ext = 0;
            pfx_brk = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic do_reset;
        ps2c = 1'b1; ps2d = 1'b1; rd_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        model_clear();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~(^b)) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            repeat (8) @(negedge clk);
            ps2c = 1'b0;
            repeat (14) @(negedge clk);
            ps2c = 1'b1;
            repeat (8) @(negedge clk);
        end
        ps2d = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
        model_byte(b);
    endtask

    task automatic pop_one;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        for (int k = 0; k < 2; k++) if (m_q[k].size() > 0) void'(m_q[k].pop_front());
        @(negedge clk);
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 9))
            0, 1:    return 8'hE0;
            2:       return 8'hF0;
            3, 4:    return arrows[$urandom_range(0, 3)];
            5:       return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            6:       return 8'h58;
            default: return 8'($urandom_range(1, 127));
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (empty[k] !== 1'b1) begin n_fail++; $display("FAIL reset_empty[%0d]: got %b want 1", k, empty[k]); end
            n_checks++; if (full[k] !== 1'b0) begin n_fail++; $display("FAIL reset_full[%0d]: got %b want 0", k, full[k]); end
            n_checks++; if (ev_data[k] !== 10'h000) begin n_fail++; $display("FAIL reset_ev_data[%0d]: got %h want 000", k, ev_data[k]); end
            n_checks++; if (held[k] !== 4'h0) begin n_fail++; $display("FAIL reset_held[%0d]: got %b want 0000", k, held[k]); end
            n_checks++; if ({shift_held[k], caps_on[k]} !== 2'b00) begin n_fail++; $display("FAIL reset_shift_caps[%0d]: got %b want 00", k, {shift_held[k], caps_on[k]}); end
            n_checks++; if ({overflow[k], frame_err[k]} !== 2'b00) begin n_fail++; $display("FAIL reset_flags[%0d]: got %b want 00", k, {overflow[k], frame_err[k]}); end
        end
    endtask

    task automatic test_basic;
        send_byte(8'h1C);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (empty[k] !== 1'b0 || ev_data[k] !== 10'h01C) begin n_fail++; $display("FAIL basic_make[%0d]: got %h empty=%b want 01c", k, ev_data[k], empty[k]); end
        end
        pop_one();
        send_byte(8'hF0);
        send_byte(8'h1C);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (empty[k] !== 1'b0 || ev_data[k] !== 10'h21C) begin n_fail++; $display("FAIL basic_break[%0d]: got %h empty=%b want 21c", k, ev_data[k], empty[k]); end
        end
        pop_one();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (empty[k] !== 1'b1) begin n_fail++; $display("FAIL basic_drained[%0d]: got %b want 1", k, empty[k]); end
        end
    endtask

    task automatic test_ext_tracked;
        send_byte(8'hE0);
        send_byte(8'h75);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ev_data[k] !== 10'h175) begin n_fail++; $display("FAIL ext_make[%0d]: got %h want 175", k, ev_data[k]); end
            n_checks++; if (held[k] !== 4'b0001) begin n_fail++; $display("FAIL ext_held_set[%0d]: got %b want 0001", k, held[k]); end
        end
        pop_one();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ev_data[k] !== 10'h375) begin n_fail++; $display("FAIL ext_break[%0d]: got %h want 375", k, ev_data[k]); end
            n_checks++; if (held[k] !== 4'b0000) begin n_fail++; $display("FAIL ext_held_clr[%0d]: got %b want 0000", k, held[k]); end
        end
        pop_one();
    endtask

    task automatic test_frame_err;
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (empty[k] !== 1'b1) begin n_fail++; $display("FAIL parity_no_event[%0d]: empty=%b want 1", k, empty[k]); end
            n_checks++; if (frame_err[k] !== 1'b1) begin n_fail++; $display("FAIL parity_frame_err[%0d]: got %b want 1", k, frame_err[k]); end
        end
        send_frame(8'h2A, 1'b0, 1'b1, 11);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (empty[k] !== 1'b1) begin n_fail++; $display("FAIL stop_no_event[%0d]: empty=%b want 1", k, empty[k]); end
        end
        send_byte(8'h1C);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ev_data[k] !== 10'h01C || frame_err[k] !== 1'b1) begin n_fail++; $display("FAIL err_recover[%0d]: got %h err=%b want 01c err=1", k, ev_data[k], frame_err[k]); end
        end
        pop_one();
    endtask

    task automatic test_overflow;
        logic [7:0] codes [9];
        do_reset();
        for (int i = 0; i < 9; i++) begin
            codes[i] = 8'($urandom_range(1, 127));
            send_byte(codes[i]);
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (full[k] !== 1'b1) begin n_fail++; $display("FAIL ovf_full[%0d]: got %b want 1", k, full[k]); end
            n_checks++; if (overflow[k] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b want 1", k, overflow[k]); end
        end
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++; if (empty[k] !== 1'b0 || ev_data[k] !== {2'b00, codes[i]}) begin n_fail++; $display("FAIL ovf_order[%0d][%0d]: got %h want %h", k, i, ev_data[k], {2'b00, codes[i]}); end
            end
            pop_one();
        end
        pop_one();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (empty[k] !== 1'b1 || full[k] !== 1'b0) begin n_fail++; $display("FAIL ovf_drained[%0d]: empty=%b full=%b want 1/0", k, empty[k], full[k]); end
        end
    endtask

    task automatic test_pause;
        logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
        for (int i = 0; i < 9; i++) send_byte(seq[i]);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (empty[k] !== 1'b0 || ev_data[k] !== 10'h029) begin n_fail++; $display("FAIL pause_event[%0d]: got %h empty=%b want 029", k, ev_data[k], empty[k]); end
        end
        pop_one();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (empty[k] !== 1'b1) begin n_fail++; $display("FAIL pause_single[%0d]: empty=%b want 1", k, empty[k]); end
        end
    endtask

    task automatic test_repeat_caps;
        logic [7:0] caps_seq [4] = '{8'h58, 8'h58, 8'hF0, 8'h58};
        for (int r = 0; r < 3; r++) begin
            send_byte(8'hE0);
            send_byte(8'h75);
        end
        n_checks++; if (m_q[1].size() != 1 || m_q[0].size() != 3) begin n_fail++; $display("FAIL repeat_model: sizes %0d/%0d want 3/1", m_q[0].size(), m_q[1].size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (empty[0] !== 1'b0 || ev_data[0] !== 10'h175) begin n_fail++; $display("FAIL repeat_on[%0d]: got %h empty=%b want 175", i, ev_data[0], empty[0]); end
            n_checks++; if ((i == 0) ? (ev_data[1] !== 10'h175) : (empty[1] !== 1'b1)) begin n_fail++; $display("FAIL repeat_off[%0d]: got %h empty=%b", i, ev_data[1], empty[1]); end
            pop_one();
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        pop_one();
        for (int i = 0; i < 4; i++) begin
            send_byte(caps_seq[i]);
            if (caps_seq[i] == 8'hF0) continue;
            for (int k = 0; k < 2; k++) begin
                n_checks++; if (caps_on[k] !== 1'b1) begin n_fail++; $display("FAIL caps_on[%0d][%0d]: got %b want 1", k, i, caps_on[k]); end
            end
        end
        for (int i = 0; i < 3; i++) pop_one();
        send_frame(8'h1C, 1'b0, 1'b0, 5);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if ({empty[k], full[k], caps_on[k], shift_held[k], overflow[k], frame_err[k]} !== 6'b100000 || held[k] !== 4'h0 || ev_data[k] !== 10'h0) begin
                n_fail++; $display("FAIL midframe_reset[%0d]: e/f/c/s/o/fe=%b held=%b ev=%h", k, {empty[k], full[k], caps_on[k], shift_held[k], overflow[k], frame_err[k]}, held[k], ev_data[k]);
            end
        end
        send_byte(8'h1C);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (ev_data[k] !== 10'h01C || empty[k] !== 1'b0) begin n_fail++; $display("FAIL post_reset_frame[%0d]: got %h want 01c", k, ev_data[k]); end
        end
        pop_one();
    endtask

    task automatic test_random;
        logic [7:0] b;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            b = pick_byte();
            send_byte(b);
            for (int k = 0; k < 2; k++) begin
                if (m_q[k].size() > 0) begin
                    n_checks++; if (empty[k] !== 1'b0 || ev_data[k] !== m_q[k][0]) begin n_fail++; $display("FAIL rand_head[%0d] byte %0d: got %h empty=%b want %h", k, n, ev_data[k], empty[k], m_q[k][0]); end
                end else begin
                    n_checks++; if (empty[k] !== 1'b1) begin n_fail++; $display("FAIL rand_empty[%0d] byte %0d: got %b want 1", k, n, empty[k]); end
                end
                n_checks++; if (full[k] !== (m_q[k].size() == DEPTH)) begin n_fail++; $display("FAIL rand_full[%0d] byte %0d: got %b", k, n, full[k]); end
                n_checks++; if (held[k] !== m_held[k]) begin n_fail++; $display("FAIL rand_held[%0d] byte %0d: got %b want %b", k, n, held[k], m_held[k]); end
                n_checks++; if (shift_held[k] !== (m_sl[k] | m_sr[k])) begin n_fail++; $display("FAIL rand_shift[%0d] byte %0d: got %b want %b", k, n, shift_held[k], m_sl[k] | m_sr[k]); end
                n_checks++; if (caps_on[k] !== m_caps[k]) begin n_fail++; $display("FAIL rand_caps[%0d] byte %0d: got %b want %b", k, n, caps_on[k], m_caps[k]); end
                n_checks++; if (overflow[k] !== m_ovf[k] || frame_err[k] !== m_ferr) begin n_fail++; $display("FAIL rand_flags[%0d] byte %0d: got %b%b want %b%b", k, n, overflow[k], frame_err[k], m_ovf[k], m_ferr); end
            end
            if ($urandom_range(0, 2) == 0) pop_one();
        end
    endtask

    initial begin
        model_clear();
        do_reset();
        test_reset();
        test_basic();
        test_ext_tracked();
        test_frame_err();
        test_overflow();
        test_pause();
        test_repeat_caps();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
